// File: rtl/block_instr_fetch_pkg.sv
// ============================================================================
//  Module   : block_instr_fetch_pkg
//  Purpose  : Shared types and constants for the instruction fetch block:
//             FSM state encoding, output FIFO depth, instruction word width.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Instruction width normally comes from the block-level header; fall back to
// the block's standard 24-bit word when that header is not in the build.
`ifndef BLOCK_INSTR_WIDTH
`define BLOCK_INSTR_WIDTH 24
`endif

package block_instr_fetch_pkg;

  // Width of one instruction word as seen by the decoder.
  localparam int c_instr_w = `BLOCK_INSTR_WIDTH;

  // Depth of the output buffer between program memory and the decoder.
  localparam int c_fifo_depth = 2;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/block_instr_fetch_if.sv
// ============================================================================
//  Module   : block_instr_fetch_if
//  Purpose  : Valid/ready instruction stream from the fetch unit to the
//             decoder. The fetch unit is the master.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface block_instr_fetch_if
  import block_instr_fetch_pkg::*;
  ();

  logic [c_instr_w-1:0] instr;
  logic                 instr_valid;
  logic                 instr_ready;
  logic                 instr_last;

  modport master (
    output instr,
    output instr_valid,
    output instr_last,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_valid,
    input  instr_last,
    output instr_ready
  );

endinterface

`default_nettype wire

// File: rtl/block_instr_fetch_instr_fifo2.sv
// ============================================================================
//  Module   : instr_fifo2
//  Purpose  : Two-entry valid/ready FIFO. The head entry drives out_data while
//             out_valid is high and only changes on a pop, so the consumer
//             sees stable data across stalls.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fifo2
  import block_instr_fetch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             in_valid,
  output logic                  in_ready,
  input  wire logic [WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  wire logic             out_ready,
  output logic [WIDTH-1:0]      out_data
);

  // Depth is fixed at two, so one-bit pointers wrap naturally.
  logic [WIDTH-1:0] r_slot [c_fifo_depth];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign in_ready  = (r_count < 2'(c_fifo_depth));
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_slot[r_rd_ptr];
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Entry storage; contents are meaningless until marked valid by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_slot[r_wr_ptr] <= in_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/block_instr_fetch.sv
// ============================================================================
//  Module   : block_instr_fetch
//  Purpose  : Program memory plus fetch sequencer. Each accepted sample_tick
//             streams instructions 0..len-1 to the decoder over a valid/ready
//             handshake, flagging the final word and pulsing done afterwards.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_instr_fetch
  import block_instr_fetch_pkg::*;
#(
  parameter int data_width = 16,
  parameter int n_instrs   = 64,
  localparam int c_pc_w    = $clog2(n_instrs)
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  input  wire logic                 sample_tick,
  input  wire logic                 prog_wr_en,
  input  wire logic [c_pc_w-1:0]    prog_wr_addr,
  input  wire logic [c_instr_w-1:0] prog_wr_data,
  input  wire logic [c_pc_w:0]      prog_len,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun,
  output logic                      wr_reject,
  block_instr_fetch_if.master       fetch
);

  // Kept only so the decoder and fetch unit share one parameter set.
  localparam int c_unused_data_width = data_width;

  localparam logic [c_pc_w:0] c_len_max = (c_pc_w + 1)'(n_instrs);
  localparam logic [c_pc_w:0] c_pc_one  = (c_pc_w + 1)'(1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_pc_w:0]        r_len;
  logic [c_pc_w:0]        r_pc;
  logic                   r_done;
  logic                   r_overrun;
  logic                   r_wr_reject;
  logic [c_instr_w-1:0]   r_prog_mem [n_instrs];

  logic                   w_tick_ok;
  logic [c_pc_w:0]        w_eff_len;
  logic                   w_issue;
  logic                   w_issue_last;
  logic                   w_fifo_in_ready;
  logic                   w_head_valid;
  logic                   w_head_last;
  logic [c_instr_w-1:0]   w_head_instr;
  logic                   w_xfer_last;

  assign w_tick_ok    = sample_tick && (r_state == ST_IDLE);
  assign w_eff_len    = (prog_len > c_len_max) ? c_len_max : prog_len;
  assign w_issue_last = ((r_pc + c_pc_one) == r_len);
  assign w_xfer_last  = w_head_valid && fetch.instr_ready && w_head_last;

  // The memory's synchronous read register is the FIFO slot itself: a read
  // issued this cycle is written into the FIFO at the next edge, so no read
  // is ever outstanding across an edge and FIFO space alone gates issue.
  instr_fifo2 #(
    .WIDTH (c_instr_w + 1)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (w_issue),
    .in_ready  (w_fifo_in_ready),
    .in_data   ({w_issue_last, r_prog_mem[r_pc[c_pc_w-1:0]]}),
    .out_valid (w_head_valid),
    .out_ready (fetch.instr_ready),
    .out_data  ({w_head_last, w_head_instr})
  );

  assign fetch.instr_valid = w_head_valid;
  assign fetch.instr_last  = w_head_valid && w_head_last;
  assign fetch.instr       = w_head_valid ? w_head_instr : '0;
  assign busy              = (r_state != ST_IDLE);
  assign done              = r_done;
  assign overrun           = r_overrun;
  assign wr_reject         = r_wr_reject;

  // Next-state and read-issue decode.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_tick_ok && (w_eff_len != '0)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_issue = w_fifo_in_ready;
        if (w_fifo_in_ready && w_issue_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_xfer_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pass length is latched and PC restarts on the accepting tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len <= '0;
      r_pc  <= '0;
    end else if (w_tick_ok) begin
      r_len <= w_eff_len;
      r_pc  <= '0;
    end else if (w_issue) begin
      r_pc  <= r_pc + c_pc_one;
    end
  end

  // Status pulses and the sticky overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_wr_reject <= 1'b0;
    end else begin
      r_done      <= (w_tick_ok && (w_eff_len == '0)) ||
                     ((r_state == ST_DRAIN) && w_xfer_last);
      r_wr_reject <= prog_wr_en && (r_state != ST_IDLE);
      if (sample_tick && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Program memory: writable only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (prog_wr_en && (r_state == ST_IDLE)) begin
      r_prog_mem[prog_wr_addr] <= prog_wr_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_block_instr_fetch.sv
// ============================================================================
//  Module   : tb_block_instr_fetch
//  Purpose  : Self-checking bench for block_instr_fetch. Expected streams come
//             from a word-array model of program memory and the pass rules.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_instr_fetch;
  import block_instr_fetch_pkg::*;

  localparam int N  = 64;
  localparam int PW = 6;

  typedef struct {
    int len;
    int mode;     // 0: ready high, 1: ready toggles, 2: random ready
    int exp_cnt;  // words the pass must deliver
  } vec_t;

  logic                 clk          = 1'b0;
  logic                 reset_n      = 1'b0;
  logic                 sample_tick  = 1'b0;
  logic                 prog_wr_en   = 1'b0;
  logic [PW-1:0]        prog_wr_addr = '0;
  logic [c_instr_w-1:0] prog_wr_data = '0;
  logic [PW:0]          prog_len     = '0;
  logic                 busy;
  logic                 done;
  logic                 overrun;
  logic                 wr_reject;

  logic [c_instr_w-1:0] model_mem [N];
  int                   n_tests = 0;
  int                   n_fail  = 0;
  vec_t                 vecs [7];

  block_instr_fetch_if fetch_if ();

  block_instr_fetch #(
    .data_width (16),
    .n_instrs   (N)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_tick  (sample_tick),
    .prog_wr_en   (prog_wr_en),
    .prog_wr_addr (prog_wr_addr),
    .prog_wr_data (prog_wr_data),
    .prog_len     (prog_len),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .wr_reject    (wr_reject),
    .fetch        (fetch_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_word(input int addr, input logic [c_instr_w-1:0] data);
    prog_wr_en   = 1'b1;
    prog_wr_addr = PW'(addr);
    prog_wr_data = data;
    step();
    prog_wr_en   = 1'b0;
    model_mem[addr] = data;
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  // One full pass: tick, then collect words until the expected count has
  // been accepted, checking order, last flag, stall stability and timing.
  task automatic run_pass(input int len, input int mode, input int exp_cnt, input string tag);
    int cyc, n_got, first_valid, first_hs, last_hs;
    bit prev_stall, finished;
    logic [c_instr_w-1:0] held;
    logic held_last;
    prog_len    = (PW + 1)'(len);
    sample_tick = 1'b1;
    fetch_if.instr_ready = ready_for(mode, 0);
    step();
    sample_tick = 1'b0;
    if (exp_cnt == 0) begin
      chk({tag, "_zero_done"}, 32'(done), 32'd1);
      chk({tag, "_zero_busy"}, 32'(busy), 32'd0);
      chk({tag, "_zero_valid"}, 32'(fetch_if.instr_valid), 32'd0);
      step();
      chk({tag, "_zero_done_off"}, 32'(done), 32'd0);
      chk({tag, "_zero_busy2"}, 32'(busy), 32'd0);
      chk({tag, "_zero_valid2"}, 32'(fetch_if.instr_valid), 32'd0);
      return;
    end
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_no_early_valid"}, 32'(fetch_if.instr_valid), 32'd0);
    cyc = 1; n_got = 0; first_valid = -1; first_hs = -1; last_hs = -1;
    prev_stall = 1'b0; finished = 1'b0; held = '0; held_last = 1'b0;
    while (!finished && cyc < 600) begin
      fetch_if.instr_ready = ready_for(mode, cyc);
      if (fetch_if.instr_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (prev_stall) begin
          chk({tag, "_stall_instr"}, 32'(fetch_if.instr), 32'(held));
          chk({tag, "_stall_last"}, 32'(fetch_if.instr_last), 32'(held_last));
        end
        if (fetch_if.instr_ready) begin
          chk({tag, "_data"}, 32'(fetch_if.instr), 32'(model_mem[n_got]));
          chk({tag, "_last"}, 32'(fetch_if.instr_last), 32'(n_got == exp_cnt - 1));
          if (first_hs < 0) first_hs = cyc;
          last_hs    = cyc;
          n_got++;
          prev_stall = 1'b0;
          if (n_got == exp_cnt) finished = 1'b1;
        end else begin
          prev_stall = 1'b1;
          held       = fetch_if.instr;
          held_last  = fetch_if.instr_last;
        end
      end
      chk({tag, "_no_done_mid"}, 32'(done), 32'd0);
      step();
      cyc++;
    end
    chk({tag, "_word_count"}, 32'(n_got), 32'(exp_cnt));
    chk({tag, "_first_valid_cycle"}, 32'(first_valid), 32'd2);
    if (mode == 0) chk({tag, "_no_bubbles"}, 32'(last_hs - first_hs), 32'(exp_cnt - 1));
    chk({tag, "_done_pulse"}, 32'(done), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_valid_end"}, 32'(fetch_if.instr_valid), 32'd0);
    step();
    chk({tag, "_done_off"}, 32'(done), 32'd0);
  endtask

  initial begin
    int len;
    fetch_if.instr_ready = 1'b0;

    vecs[0] = '{len: 4,   mode: 0, exp_cnt: 4};
    vecs[1] = '{len: 4,   mode: 1, exp_cnt: 4};
    vecs[2] = '{len: 0,   mode: 0, exp_cnt: 0};
    vecs[3] = '{len: 100, mode: 0, exp_cnt: 64};
    vecs[4] = '{len: 64,  mode: 1, exp_cnt: 64};
    vecs[5] = '{len: 1,   mode: 0, exp_cnt: 1};
    vecs[6] = '{len: 127, mode: 2, exp_cnt: 64};

    // Reset state.
    reset_n = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(fetch_if.instr_valid), 32'd0);
    chk("rst_last", 32'(fetch_if.instr_last), 32'd0);
    chk("rst_instr", 32'(fetch_if.instr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_wr_reject", 32'(wr_reject), 32'd0);
    reset_n = 1'b1;
    step();

    // Fill memory with known contents, then the reference program.
    for (int i = 0; i < N; i++) write_word(i, c_instr_w'(24'h100 + i * 7));
    for (int i = 0; i < 4; i++) write_word(i, c_instr_w'(24'h11 + i));
    chk("idle_write_no_reject", 32'(wr_reject), 32'd0);

    // Table-driven passes.
    for (int v = 0; v < 7; v++) begin
      run_pass(vecs[v].len, vecs[v].mode, vecs[v].exp_cnt, $sformatf("vec%0d", v));
      step();
    end

    // Tick and write while busy: ignored, overrun sticks, reject pulses once.
    fetch_if.instr_ready = 1'b1;
    prog_len    = 7'd4;
    sample_tick = 1'b1;
    step();
    sample_tick  = 1'b1;
    prog_len     = 7'd1;
    prog_wr_en   = 1'b1;
    prog_wr_addr = '0;
    prog_wr_data = c_instr_w'(24'hAA);
    step();
    sample_tick = 1'b0;
    prog_wr_en  = 1'b0;
    chk("ovr_overrun_set", 32'(overrun), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ovr_valid", 32'(fetch_if.instr_valid), 32'd1);
      chk("ovr_data", 32'(fetch_if.instr), 32'(24'h11 + i));
      chk("ovr_last", 32'(fetch_if.instr_last), 32'(i == 3));
      if (i == 0) chk("ovr_reject_pulse", 32'(wr_reject), 32'd1);
      if (i == 1) chk("ovr_reject_once", 32'(wr_reject), 32'd0);
      step();
    end
    chk("ovr_done", 32'(done), 32'd1);
    chk("ovr_busy_end", 32'(busy), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    step();
    run_pass(1, 0, 1, "mem0_unchanged");
    chk("ovr_sticky_later", 32'(overrun), 32'd1);

    // Tick together with a write in IDLE: the pass sees the new word.
    fetch_if.instr_ready = 1'b1;
    prog_wr_en   = 1'b1;
    prog_wr_addr = '0;
    prog_wr_data = c_instr_w'(24'h5A);
    prog_len     = 7'd1;
    sample_tick  = 1'b1;
    step();
    prog_wr_en  = 1'b0;
    sample_tick = 1'b0;
    model_mem[0] = c_instr_w'(24'h5A);
    chk("simul_busy", 32'(busy), 32'd1);
    chk("simul_no_reject", 32'(wr_reject), 32'd0);
    step();
    chk("simul_valid", 32'(fetch_if.instr_valid), 32'd1);
    chk("simul_data", 32'(fetch_if.instr), 32'h5A);
    chk("simul_last", 32'(fetch_if.instr_last), 32'd1);
    step();
    chk("simul_done", 32'(done), 32'd1);
    step();

    // Reset in the middle of a pass after two words have been taken.
    write_word(0, c_instr_w'(24'h11));
    fetch_if.instr_ready = 1'b1;
    prog_len    = 7'd4;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    step();
    chk("midrst_third_word", 32'(fetch_if.instr), 32'h13);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(fetch_if.instr_valid), 32'd0);
    chk("midrst_last", 32'(fetch_if.instr_last), 32'd0);
    chk("midrst_instr", 32'(fetch_if.instr), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    chk("midrst_reject", 32'(wr_reject), 32'd0);
    step();
    step();
    chk("midrst_no_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    step();
    chk("midrst_no_done_after", 32'(done), 32'd0);
    run_pass(4, 0, 4, "replay");
    step();

    // Randomized programs, lengths and back-pressure.
    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < 4; w++) begin
        write_word(int'($urandom_range(0, N - 1)), c_instr_w'($urandom()));
      end
      len = int'($urandom_range(0, 100));
      run_pass(len, 2, (len > N) ? N : len, $sformatf("rand%0d", r));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
